// File: rtl/control_sequencer_if.sv
// Bus, ALU flag inputs and control lines of the SAP-style control sequencer.
// The master modport is the sequencer; the slave modport is the datapath side.
interface control_sequencer_if #(
    parameter int N = 8
);
    logic [N-1:0] bus;
    logic         cf;
    logic         zf;
    logic [N-1:0] operand;
    logic [1:0]   flags;
    logic [2:0]   step;
    logic hlt, mi, ri, ii, ai, bi, oi, ce, j, fi, su;
    logic co_, ro_, io_, ao_, eo_;

    modport master (
        input  bus, cf, zf,
        output operand, flags, step,
        output hlt, mi, ri, ii, ai, bi, oi, ce, j, fi, su,
        output co_, ro_, io_, ao_, eo_
    );

    modport slave (
        output bus, cf, zf,
        input  operand, flags, step,
        input  hlt, mi, ri, ii, ai, bi, oi, ce, j, fi, su,
        input  co_, ro_, io_, ao_, eo_
    );
endinterface

// File: rtl/control_sequencer.sv
// Five T-state microcoded control sequencer with IR, flag register and halt latch.
// Optional build macro CONDJMP_EN adds the JC (0x7) and JZ (0x8) conditional jumps.
module control_sequencer #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    control_sequencer_if.master   cs
);
    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_e;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    tstate_e      state, state_nx;
    logic [N-1:0] ir, ir_nx;
    logic [1:0]   flags_q, flags_nx;
    logic         halted, halted_nx;
    logic [3:0]   op;

    logic hlt, mi, ri, ii, ai, bi, oi, ce, j, fi, su;
    logic co, ro, io, ao, eo;  // active-high internal view of the bus enables

    assign op = ir[7:4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= T0;
            ir      <= '0;
            flags_q <= '0;
            halted  <= 1'b0;
        end else begin
            state   <= state_nx;
            ir      <= ir_nx;
            flags_q <= flags_nx;
            halted  <= halted_nx;
        end
    end

    always_comb begin
        hlt = 1'b0; mi = 1'b0; ri = 1'b0; ii = 1'b0; ai = 1'b0; bi = 1'b0;
        oi  = 1'b0; ce = 1'b0; j  = 1'b0; fi = 1'b0; su = 1'b0;
        co  = 1'b0; ro = 1'b0; io = 1'b0; ao = 1'b0; eo = 1'b0;
        state_nx  = state;
        ir_nx     = ir;
        flags_nx  = flags_q;
        halted_nx = halted;

        case (state)
            T0: begin co = 1'b1; mi = 1'b1; end
            T1: begin ro = 1'b1; ii = 1'b1; ce = 1'b1; end
            T2: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin io = 1'b1; mi = 1'b1; end
                    OP_LDI: begin io = 1'b1; ai = 1'b1; end
                    OP_JMP: begin io = 1'b1; j = 1'b1; end
`ifdef CONDJMP_EN
                    OP_JC:  begin io = 1'b1; j = flags_q[1]; end
                    OP_JZ:  begin io = 1'b1; j = flags_q[0]; end
`endif
                    OP_OUT: begin ao = 1'b1; oi = 1'b1; end
                    OP_HLT: hlt = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                case (op)
                    OP_LDA:         begin ro = 1'b1; ai = 1'b1; end
                    OP_ADD, OP_SUB: begin ro = 1'b1; bi = 1'b1; end
                    OP_STA:         begin ao = 1'b1; ri = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    eo = 1'b1; ai = 1'b1; fi = 1'b1;
                    su = (op == OP_SUB);
                end
            end
            default: ;
        endcase

        // Once halted, every register freezes and hlt is held until reset.
        if (halted) begin
            hlt = 1'b1;
        end else begin
            if (fi) flags_nx = {cs.cf, cs.zf};
            if (hlt) begin
                halted_nx = 1'b1;
            end else begin
                if (state == T1) ir_nx = cs.bus;
                case (state)
                    T0:      state_nx = T1;
                    T1:      state_nx = T2;
                    T2:      state_nx = T3;
                    T3:      state_nx = T4;
                    default: state_nx = T0;
                endcase
            end
        end
    end

    assign cs.operand = {{(N-4){1'b0}}, ir[3:0]};
    assign cs.flags   = flags_q;
    assign cs.step    = state;
    assign cs.hlt = hlt;
    assign cs.mi  = mi;
    assign cs.ri  = ri;
    assign cs.ii  = ii;
    assign cs.ai  = ai;
    assign cs.bi  = bi;
    assign cs.oi  = oi;
    assign cs.ce  = ce;
    assign cs.j   = j;
    assign cs.fi  = fi;
    assign cs.su  = su;
    assign cs.co_ = ~co;
    assign cs.ro_ = ~ro;
    assign cs.io_ = ~io;
    assign cs.ao_ = ~ao;
    assign cs.eo_ = ~eo;
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: vector table, corner-case
// sequences and random stimulus against a microcode-table reference model.
module tb_control_sequencer;
  localparam int N = 8;
  localparam int W = 29;

  localparam logic [15:0] C_HLT = 16'h8000, C_MI = 16'h4000, C_RI = 16'h2000,
                          C_II = 16'h1000, C_AI = 16'h0800, C_BI = 16'h0400,
                          C_OI = 16'h0200, C_CE = 16'h0100, C_J  = 16'h0080,
                          C_FI = 16'h0040, C_SU = 16'h0020, C_CO = 16'h0010,
                          C_RO = 16'h0008, C_IO = 16'h0004, C_AO = 16'h0002,
                          C_EO = 16'h0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_sequencer_if #(.N(N)) cs();
  control_sequencer #(.N(N)) dut (.clk(clk), .rst(rst), .cs(cs.master));

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [15:0] mc[16][5];
  int m_ir, m_step, m_flags;
  bit m_halted;

  function automatic logic [15:0] model_ctrl(int op, int st, int fl);
    logic [15:0] c;
    c = mc[op][st];
`ifdef CONDJMP_EN
    if (st == 2 && op == 7) c = C_IO | ((fl & 2) != 0 ? C_J : 16'h0);
    if (st == 2 && op == 8) c = C_IO | ((fl & 1) != 0 ? C_J : 16'h0);
`endif
    return c;
  endfunction

  function automatic logic [15:0] cur_model_ctrl();
    return model_ctrl(m_ir / 16, m_step, m_flags);
  endfunction

  task automatic model_edge();
    logic [15:0] c;
    c = cur_model_ctrl();
    if (rst) begin
      m_ir = 0; m_step = 0; m_flags = 0; m_halted = 0;
    end else if (!m_halted) begin
      if ((c & C_FI) != 0) m_flags = 2 * int'(cs.cf) + int'(cs.zf);
      if ((c & C_HLT) != 0) m_halted = 1;
      else begin
        if (m_step == 1) m_ir = int'(cs.bus);
        m_step = (m_step + 1) % 5;
      end
    end
  endtask

  function automatic logic [15:0] dut_ctrl();
    return {cs.hlt, cs.mi, cs.ri, cs.ii, cs.ai, cs.bi, cs.oi, cs.ce, cs.j, cs.fi, cs.su,
            ~cs.co_, ~cs.ro_, ~cs.io_, ~cs.ao_, ~cs.eo_};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string name);
    logic [W-1:0] act, exp;
    int lows;
    exp_q.push_back({8'(m_ir % 16), 3'(m_step), 2'(m_flags), cur_model_ctrl()});
    act = {cs.operand, cs.step, cs.flags, dut_ctrl()};
    exp = exp_q.pop_front();
    chk(name, 32'(act), 32'(exp));
    lows = int'(!cs.co_) + int'(!cs.ro_) + int'(!cs.io_) + int'(!cs.ao_) + int'(!cs.eo_);
    chk({name, "_bus_enables"}, 32'(lows > 1), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(string name = "cycle");
    @(posedge clk);
    model_edge();
    #1;
    check_all(name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick("reset");
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  bus;
    logic [15:0] e2, e3, e4;
  } vec_t;

`ifdef CONDJMP_EN
  localparam logic [15:0] CJ2 = C_IO;
`else
  localparam logic [15:0] CJ2 = 16'h0;
`endif

  initial begin
    vec_t vecs[15];
    cs.bus = '0; cs.cf = 1'b0; cs.zf = 1'b0;
    for (int o = 0; o < 16; o++) begin
      mc[o][0] = C_CO | C_MI;
      mc[o][1] = C_RO | C_II | C_CE;
      mc[o][2] = 16'h0; mc[o][3] = 16'h0; mc[o][4] = 16'h0;
    end
    mc[1][2] = C_IO | C_MI; mc[1][3] = C_RO | C_AI;
    mc[2][2] = C_IO | C_MI; mc[2][3] = C_RO | C_BI; mc[2][4] = C_EO | C_AI | C_FI;
    mc[3][2] = C_IO | C_MI; mc[3][3] = C_RO | C_BI; mc[3][4] = C_EO | C_AI | C_FI | C_SU;
    mc[4][2] = C_IO | C_MI; mc[4][3] = C_AO | C_RI;
    mc[5][2] = C_IO | C_AI;
    mc[6][2] = C_IO | C_J;
    mc[14][2] = C_AO | C_OI;
    mc[15][2] = C_HLT;

    vecs = '{
      '{8'h05, 16'h0, 16'h0, 16'h0},
      '{8'h1E, C_IO|C_MI, C_RO|C_AI, 16'h0},
      '{8'h2A, C_IO|C_MI, C_RO|C_BI, C_EO|C_AI|C_FI},
      '{8'h3F, C_IO|C_MI, C_RO|C_BI, C_EO|C_AI|C_FI|C_SU},
      '{8'h47, C_IO|C_MI, C_AO|C_RI, 16'h0},
      '{8'h53, C_IO|C_AI, 16'h0, 16'h0},
      '{8'h69, C_IO|C_J, 16'h0, 16'h0},
      '{8'hE1, C_AO|C_OI, 16'h0, 16'h0},
      '{8'h9C, 16'h0, 16'h0, 16'h0},
      '{8'hA0, 16'h0, 16'h0, 16'h0},
      '{8'hB5, 16'h0, 16'h0, 16'h0},
      '{8'hC1, 16'h0, 16'h0, 16'h0},
      '{8'hD7, 16'h0, 16'h0, 16'h0},
      '{8'h75, CJ2, 16'h0, 16'h0},
      '{8'h85, CJ2, 16'h0, 16'h0}
    };

    // Vector table: one instruction after reset, T0..T4 against constants.
    for (int v = 0; v < 15; v++) begin
      cs.cf = 1'b0; cs.zf = 1'b0;
      do_reset();
      chk("t0_ctrl", 32'(dut_ctrl()), 32'(C_CO | C_MI));
      cs.bus = vecs[v].bus;
      tick();
      chk("t1_ctrl", 32'(dut_ctrl()), 32'(C_RO | C_II | C_CE));
      tick();
      chk("t2_ctrl", 32'(dut_ctrl()), 32'(vecs[v].e2));
      chk("t2_operand", 32'(cs.operand), 32'(vecs[v].bus & 8'h0F));
      tick();
      chk("t3_ctrl", 32'(dut_ctrl()), 32'(vecs[v].e3));
      tick();
      chk("t4_ctrl", 32'(dut_ctrl()), 32'(vecs[v].e4));
      tick();
      chk("wrap_step", 32'(cs.step), 32'd0);
    end

    // SUB with carry set: flags become {CF,ZF}=10 after T4.
    cs.bus = 8'h3F; cs.cf = 1'b1; cs.zf = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("sub_t4_ctrl", 32'(dut_ctrl()), 32'(C_EO | C_AI | C_FI | C_SU));
    tick();
    chk("sub_flags", 32'(cs.flags), 32'd2);

    // Flags=01 via ADD, then JC and JZ.
    cs.bus = 8'h20; cs.cf = 1'b0; cs.zf = 1'b1;
    do_reset();
    repeat (5) tick();
    chk("add_flags", 32'(cs.flags), 32'd1);
    cs.cf = 1'b1; cs.zf = 1'b1;
    cs.bus = 8'h75;
    repeat (2) tick();
`ifdef CONDJMP_EN
    chk("jc_j_io", 32'({cs.j, cs.io_}), 32'b00);
`else
    chk("jc_j_io", 32'({cs.j, cs.io_}), 32'b01);
`endif
    repeat (3) tick();
    cs.bus = 8'h85;
    repeat (2) tick();
`ifdef CONDJMP_EN
    chk("jz_j_io", 32'({cs.j, cs.io_}), 32'b10);
`else
    chk("jz_j_io", 32'({cs.j, cs.io_}), 32'b01);
`endif
    repeat (3) tick();

    // Halt: frozen at T2 for 10 edges, only reset releases it.
    cs.bus = 8'hF0;
    do_reset();
    repeat (2) tick();
    chk("hlt_t2", 32'(dut_ctrl()), 32'(C_HLT));
    for (int i = 0; i < 10; i++) begin
      cs.bus = 8'($urandom_range(0, 255));
      cs.cf = 1'($urandom_range(0, 1)); cs.zf = 1'($urandom_range(0, 1));
      tick();
      chk("halted_step", 32'(cs.step), 32'd2);
      chk("halted_ctrl", 32'(dut_ctrl()), 32'(C_HLT));
    end
    do_reset();
    chk("unhalt_step", 32'(cs.step), 32'd0);
    chk("unhalt_hlt", 32'(cs.hlt), 32'd0);

    // Reset during ADD T4 with fi active: no flag update.
    cs.bus = 8'h2A; cs.cf = 1'b1; cs.zf = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("add_t4_fi", 32'(cs.fi), 32'd1);
    do_reset();
    chk("rst_t4_flags", 32'(cs.flags), 32'd0);
    chk("rst_t4_step", 32'(cs.step), 32'd0);

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      cs.bus = 8'($urandom_range(0, 255));
      cs.cf = 1'($urandom_range(0, 1));
      cs.zf = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 63) == 0);
      tick("random");
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, meaning bus width in bits (N >= 8).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port bus  input  N  shared data bus, sampled into instruction register.
REQ-005 SHALL have port cf, zf  input  1 each  ALU carry and zero flags, combinational from ALU.
REQ-006 SHALL have port operand  output  N  zero-extended IR[3:0] for driving bus when io_ low.
REQ-007 SHALL have port flags  output  2  registered {CF,ZF}.
REQ-008 SHALL have port step  output  3  current T-state, 0..4.
REQ-009 SHALL have ports hlt, mi, ri, ii, ai, bi, oi, ce, j, fi, su  output  1 each, active-high control lines.
REQ-010 SHALL have ports co_, ro_, io_, ao_, eo_  output  1 each, active-low bus-drive enables (eo_ feeds ALU eo_, su feeds ALU su).

Function
REQ-011 SHALL hold IR (N bits), step counter (3 bits), flag register (2 bits), halted bit.
REQ-012 step SHALL advance 0,1,2,3,4,0 each rising edge when not halted; no early termination.
REQ-013 Control outputs SHALL be pure combinational decode of (IR[7:4], step, flag register, CONDJMP_EN); inactive = high-level 0, low-level 1.
REQ-014 T0: co_=0, mi=1.  T1: ro_=0, ii=1, ce=1; IR loads bus on the edge ending T1.
REQ-015 Opcodes, T2/T3/T4: NOP 0x0 none; LDA 0x1 io_,mi / ro_,ai / none; ADD 0x2 io_,mi / ro_,bi / eo_,ai,fi; SUB 0x3 as ADD plus su=1 in T4; STA 0x4 io_,mi / ao_,ri / none; LDI 0x5 io_,ai; JMP 0x6 io_,j; OUT 0xE ao_,oi; HLT 0xF hlt in T2.
REQ-016 Undefined opcodes SHALL decode as NOP.
REQ-017 Flag register SHALL load {cf,zf} on rising edge when fi=1; otherwise hold.
REQ-018 hlt=1 at a rising edge SHALL set halted; while halted step freezes at 2, IR and flags hold, hlt stays 1; only rst clears halted.
REQ-019 At most one active-low bus enable SHALL be 0 in any state.
REQ-020 operand SHALL equal {(N-4)'b0, IR[3:0]} at all times.

Reset
REQ-021 rst=1 at rising edge SHALL set IR=0, step=0, flags=0, halted=0, overriding halt, fi and step advance.
REQ-022 After reset outputs SHALL show T0 decode: co_=0, mi=1, all other high-level 0, other low-level 1.
REQ-023 Reset asserted mid-instruction SHALL abandon it; no partial flag update from that edge.

Configuration
REQ-024 Macro CONDJMP_EN SHALL gate conditional jumps.
REQ-025 With CONDJMP_EN: JC 0x7 T2 io_=0, j=CF; JZ 0x8 T2 io_=0, j=ZF; io_ asserted regardless of flag.
REQ-026 Without CONDJMP_EN: 0x7 and 0x8 SHALL decode as NOP.

Verification
REQ-027 Reset then 5 clocks with bus=0x1E -> T0 co_=0,mi=1; T1 ro_=0,ii=1,ce=1; IR=0x1E; T2 io_=0,mi=1, operand=0x0E; T3 ro_=0,ai=1; step returns to 0.
REQ-028 IR=0x3F (SUB), T4 with cf=1, zf=0 -> eo_=0, ai=1, fi=1, su=1; flags=2'b10 next cycle.
REQ-029 CONDJMP_EN defined, flags=2'b01, IR=0x75 then 0x85 -> JC T2 j=0, io_=0; JZ T2 j=1, io_=0; undefined build: j=0, io_=1 for both.
REQ-030 IR=0xF0 reaching T2 -> hlt=1; 10 further clocks step=2, outputs unchanged; rst=1 one edge -> step=0, hlt=0.
REQ-031 rst pulsed during ADD T4 with fi=1, cf=1 -> flags=0, step=0 after edge.
REQ-032 Random bus values over 1000 cycles -> never more than one active-low enable low; undefined opcodes 0x9-0xD produce NOP.
